id_ex_control_pipe: RTL and testbench
=====================================

Name: id_ex_control_pipe

Overview:
- Pipelined successor to the combinational decode/control path.
- Decodes a 32-bit MIPS-style instruction into the EX-stage control bundle and registers it as the ID/EX control pipeline register.
- Uses valid/ready handshakes on both sides and inserts bubbles on inhibit or load-use hazard.
- Supports flush, plus a multi-cycle MULT/MULTU occupancy counter. Sits between the IF/ID register and the EX stage.

Parameters:
XLEN, 32, datapath width; MEM_BE_W = XLEN/8.
REG_ADDR_W, 5, register-specifier width.
MUL_CYCLES, 4, cycles EX is occupied by MULT/MULTU (>=1).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  instr valid from IF/ID
in_ready  out  1  stage accepts instr this cycle
instr  in  32  instruction word
inhibit  in  1  force accepted instr to bubble
flush  in  1  kill held output and any multi-cycle occupancy
out_valid  out  1  control bundle valid to EX
out_ready  in  1  EX accepts bundle
out_reg_dst  out  1  1 = rd, 0 = rt
out_reg_write  out  1  GPR write enable
out_alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded, 11 multiply
out_alu_src  out  1  1 = immediate
out_mem_write  out  MEM_BE_W  byte enables
out_mem_read  out  1  load
out_mem_to_reg  out  1  1 = ALU result, 0 = memory data
out_beq, out_bne  out  1 each  branch type
out_mul  out  1  multiply op (writes HI/LO)
out_illegal  out  1  unrecognised opcode/funct
out_dest_reg  out  REG_ADDR_W  rd if reg_dst else rt
out_instr  out  32  registered instruction

Behaviour:
- Reset: all outputs 0, state RUN, mul_cnt 0. in_ready is 0 during reset.
- Advance: `advance = out_ready | ~out_valid`. Output registers load only when advance is true or flush is asserted.
- hazard:
  - Condition: `out_valid & out_mem_read & out_dest_reg != 0`, and `out_dest_reg == instr.rs` or (`uses_rt` and `out_dest_reg == instr.rt`).
  - `uses_rt` applies to R-type, BEQ, BNE and SW.
- `in_ready = advance & state==RUN & ~hazard & ~flush & ~rst`. Acceptance is `in_valid & in_ready`.
- Accept with inhibit=0: bundle latched, out_valid=1, one-cycle latency.
- Accept with inhibit=1: instr consumed, out_valid=0 (bubble).
- Hazard stall: if advance and hazard, the output loads a bubble (out_valid=0) and the instr stays at the input. The next cycle the hazard clears because the load has left.
- No accept and advance: out_valid drops to 0.
- If advance=0: all outputs hold.
- Decode (opcode instr[31:26]):
  - 0x00 R-type: reg_dst=1, reg_write=1, alu_op=10.
  - R-type funct 0x18/0x19 (MULT/MULTU): reg_write=0, alu_op=11, mul=1.
  - 0x04 BEQ: beq=1, alu_op=01. 0x05 BNE: bne=1, alu_op=01.
  - 0x08 ADDI: reg_write=1, alu_src=1, mem_to_reg=1.
  - 0x0A SLTI: as ADDI but alu_op=01.
  - 0x23 LW: reg_write=1, alu_src=1, mem_read=1, mem_to_reg=0.
  - 0x2B SW: alu_src=1, mem_write=all ones.
  - Unlisted fields are 0 in every case.
  - Any other opcode: all controls 0, illegal=1, out_valid=1.
- FSM RUN/MUL_BUSY:
  - Accepting MULT/MULTU with MUL_CYCLES>1 sets mul_cnt = MUL_CYCLES-1 and moves to MUL_BUSY.
  - In MUL_BUSY, mul_cnt decrements every cycle; at mul_cnt==1 the state returns to RUN.
  - With MUL_CYCLES=1, the state stays in RUN.
- Flush: the next edge gives out_valid=0, state RUN, mul_cnt=0; nothing is accepted in the flush cycle.
- Priority: rst > flush > hazard > accept.

Decomposition:
- Package `cpu_ctrl_pkg`:
  - opcode/funct localparams.
  - alu_op enum.
  - `ctrl_bundle_t` struct, parametrised via MEM_BE_W/REG_ADDR_W.
  - state enum.
- Sub-module `ctrl_decode`: pure combinational instr→ctrl_bundle_t, with no latches (defaults first).
- Top: handshake, hazard, FSM/counter, registers.

Test Plan:
- Reset, then `add $8,$9,$10` (0x012A4020), in_valid=1, out_ready=1 → next cycle out_valid=1, reg_dst=1, reg_write=1, alu_op=10, dest_reg=8.
- `lw $8,0($9)` (0x8D280000), then `add $10,$8,$8` (0x01085020) → in_ready=0 for one cycle with a bubble emitted; the add emits one cycle later. Repeat with `addi` in place of the LW: no stall.
- `mult $9,$10` (0x012A0018), MUL_CYCLES=4 → out_mul=1, alu_op=11, in_ready=0 for exactly 3 cycles after accept.
- out_ready=0 for 3 cycles with a valid SW (0xAD280004) held → outputs stable, in_ready=0, mem_write=4'b1111 throughout.
- Flush in MUL_BUSY with mul_cnt=2 → next cycle out_valid=0, in_ready=1. Inhibit=1 on accept → out_valid=0.
- Opcode 0x3F → out_illegal=1, all controls 0, out_valid=1. rst asserted mid-stream → all outputs 0 on the next edge.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings and the EX-stage control bundle for the ID/EX control pipeline.
package cpu_ctrl_pkg;

   localparam int CTRL_MEM_BE_W   = 32 / 8;
   localparam int CTRL_REG_ADDR_W = 5;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10,
      ALU_MUL   = 2'b11
   } alu_op_e;

   typedef struct packed {
      logic                       reg_dst;
      logic                       reg_write;
      alu_op_e                    alu_op;
      logic                       alu_src;
      logic [CTRL_MEM_BE_W-1:0]   mem_write;
      logic                       mem_read;
      logic                       mem_to_reg;
      logic                       beq;
      logic                       bne;
      logic                       mul;
      logic                       illegal;
      logic [CTRL_REG_ADDR_W-1:0] dest_reg;
   } ctrl_bundle_t;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MUL_BUSY = 1'b1
   } state_e;

   // Opcodes whose rt field is a source operand (matters for load-use detection).
   function automatic logic uses_rt(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct decode into the EX-stage control bundle.
module ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [5:0]                 opcode,
   input  logic [5:0]                 funct,
   input  logic [CTRL_REG_ADDR_W-1:0] rt,
   input  logic [CTRL_REG_ADDR_W-1:0] rd,
   output ctrl_bundle_t               ctrl
);

   always_comb begin
      ctrl = '0;
      case (opcode)
         OP_RTYPE: begin
            ctrl.reg_dst = 1'b1;
            if (funct == FN_MULT || funct == FN_MULTU) begin
               ctrl.alu_op = ALU_MUL;
               ctrl.mul    = 1'b1;
            end else begin
               ctrl.reg_write = 1'b1;
               ctrl.alu_op    = ALU_FUNCT;
            end
         end
         OP_BEQ: begin
            ctrl.beq    = 1'b1;
            ctrl.alu_op = ALU_SUB;
         end
         OP_BNE: begin
            ctrl.bne    = 1'b1;
            ctrl.alu_op = ALU_SUB;
         end
         OP_ADDI: begin
            ctrl.reg_write  = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         OP_SLTI: begin
            ctrl.reg_write  = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.alu_op     = ALU_SUB;
         end
         OP_LW: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.mem_read  = 1'b1;
         end
         OP_SW: begin
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = '1;
         end
         default: ctrl.illegal = 1'b1;
      endcase
      ctrl.dest_reg = ctrl.reg_dst ? rd : rt;
   end

endmodule

// File: rtl/id_ex_control_pipe.sv
// ID/EX control pipeline register: decode, load-use stall, flush and multiply occupancy.
module id_ex_control_pipe
   import cpu_ctrl_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int MUL_CYCLES = 4,
   localparam int MEM_BE_W  = XLEN / 8
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           instr,
   input  logic                  inhibit,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_reg_dst,
   output logic                  out_reg_write,
   output logic [1:0]            out_alu_op,
   output logic                  out_alu_src,
   output logic [MEM_BE_W-1:0]   out_mem_write,
   output logic                  out_mem_read,
   output logic                  out_mem_to_reg,
   output logic                  out_beq,
   output logic                  out_bne,
   output logic                  out_mul,
   output logic                  out_illegal,
   output logic [REG_ADDR_W-1:0] out_dest_reg,
   output logic [31:0]           out_instr,
   output state_e                dbg_state
);

   localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

   ctrl_bundle_t     dec;
   ctrl_bundle_t     ctrl_q;
   logic             valid_q;
   logic [31:0]      instr_q;
   state_e           state_q;
   logic [CNT_W-1:0] mul_cnt_q;
   logic             advance;
   logic             hazard;
   logic             accept;

   ctrl_decode u_decode (
      .opcode (instr[31:26]),
      .funct  (instr[5:0]),
      .rt     (instr[20:16]),
      .rd     (instr[15:11]),
      .ctrl   (dec)
   );

   // Handshake: a word moves on a side only in a cycle where valid and ready are both high;
   // the output slot is free when EX takes the held bundle or nothing valid is held.
   assign advance  = out_ready | ~valid_q;
   assign hazard   = valid_q & ctrl_q.mem_read & (ctrl_q.dest_reg != '0) &
                     ((ctrl_q.dest_reg == instr[25:21]) |
                      (uses_rt(instr[31:26]) & (ctrl_q.dest_reg == instr[20:16])));
   assign in_ready = advance & (state_q == ST_RUN) & ~hazard & ~flush & ~rst;
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         valid_q   <= 1'b0;
         ctrl_q    <= '0;
         instr_q   <= '0;
         state_q   <= ST_RUN;
         mul_cnt_q <= '0;
      end else begin
         // Anything other than an uninhibited accept leaves an all-zero bubble in the slot.
         if (advance) begin
            if (accept && !inhibit) begin
               valid_q <= 1'b1;
               ctrl_q  <= dec;
               instr_q <= instr;
            end else begin
               valid_q <= 1'b0;
               ctrl_q  <= '0;
               instr_q <= '0;
            end
         end
         case (state_q)
            ST_RUN: begin
               if (accept && !inhibit && dec.mul && (MUL_CYCLES > 1)) begin
                  state_q   <= ST_MUL_BUSY;
                  mul_cnt_q <= CNT_W'(MUL_CYCLES - 1);
               end
            end
            ST_MUL_BUSY: begin
               if (mul_cnt_q == CNT_W'(1)) begin
                  state_q   <= ST_RUN;
                  mul_cnt_q <= '0;
               end else begin
                  mul_cnt_q <= mul_cnt_q - CNT_W'(1);
               end
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   assign out_valid      = valid_q;
   assign out_reg_dst    = ctrl_q.reg_dst;
   assign out_reg_write  = ctrl_q.reg_write;
   assign out_alu_op     = ctrl_q.alu_op;
   assign out_alu_src    = ctrl_q.alu_src;
   assign out_mem_write  = ctrl_q.mem_write;
   assign out_mem_read   = ctrl_q.mem_read;
   assign out_mem_to_reg = ctrl_q.mem_to_reg;
   assign out_beq        = ctrl_q.beq;
   assign out_bne        = ctrl_q.bne;
   assign out_mul        = ctrl_q.mul;
   assign out_illegal    = ctrl_q.illegal;
   assign out_dest_reg   = ctrl_q.dest_reg;
   assign out_instr      = instr_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_id_ex_control_pipe.sv
// Directed bench for id_ex_control_pipe: expected bundles queued at issue, popped by a monitor.
module tb_id_ex_control_pipe;
   import cpu_ctrl_pkg::*;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic        inhibit;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic        out_reg_dst;
   logic        out_reg_write;
   logic [1:0]  out_alu_op;
   logic        out_alu_src;
   logic [3:0]  out_mem_write;
   logic        out_mem_read;
   logic        out_mem_to_reg;
   logic        out_beq;
   logic        out_bne;
   logic        out_mul;
   logic        out_illegal;
   logic [4:0]  out_dest_reg;
   logic [31:0] out_instr;
   state_e      dbg_state;

   localparam logic [31:0] I_ADD8   = 32'h012A4020;
   localparam logic [31:0] I_ADD10  = 32'h01085020;
   localparam logic [31:0] I_ADD00  = 32'h00005020;
   localparam logic [31:0] I_LW8    = 32'h8D280000;
   localparam logic [31:0] I_LW0    = 32'h8D200000;
   localparam logic [31:0] I_ADDI   = 32'h21280000;
   localparam logic [31:0] I_SW     = 32'hAD280004;
   localparam logic [31:0] I_BEQ    = 32'h11090003;
   localparam logic [31:0] I_BNE    = 32'h15090003;
   localparam logic [31:0] I_SLTI   = 32'h29280005;
   localparam logic [31:0] I_MULT   = 32'h012A0018;
   localparam logic [31:0] I_MULTU  = 32'h012A0019;
   localparam logic [31:0] I_ILL    = 32'hFC000000;

   logic [51:0] exp_q[$];
   logic [51:0] act_vec;
   int          n_tests = 0;
   int          n_fail  = 0;

   id_ex_control_pipe dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .instr          (instr),
      .inhibit        (inhibit),
      .flush          (flush),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_reg_dst    (out_reg_dst),
      .out_reg_write  (out_reg_write),
      .out_alu_op     (out_alu_op),
      .out_alu_src    (out_alu_src),
      .out_mem_write  (out_mem_write),
      .out_mem_read   (out_mem_read),
      .out_mem_to_reg (out_mem_to_reg),
      .out_beq        (out_beq),
      .out_bne        (out_bne),
      .out_mul        (out_mul),
      .out_illegal    (out_illegal),
      .out_dest_reg   (out_dest_reg),
      .out_instr      (out_instr),
      .dbg_state      (dbg_state)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   assign act_vec = {out_reg_dst, out_reg_write, out_alu_op, out_alu_src, out_mem_write,
                     out_mem_read, out_mem_to_reg, out_beq, out_bne, out_mul, out_illegal,
                     out_dest_reg, out_instr};

   function automatic logic [51:0] pack(input logic rdst, input logic rw, input logic [1:0] op,
                                        input logic asrc, input logic [3:0] mw, input logic mr,
                                        input logic m2r, input logic bq, input logic bn,
                                        input logic ml, input logic il, input logic [4:0] dst,
                                        input logic [31:0] ins);
      return {rdst, rw, op, asrc, mw, mr, m2r, bq, bn, ml, il, dst, ins};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Scoreboard monitor: one pop per bundle transferred to EX
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_bundle: got %h, required none", act_vec);
         end else begin
            check("bundle", 64'(act_vec), 64'(exp_q.pop_front()));
         end
      end
   end

   // Driver: present an instruction until accepted, counting stalled cycles.
   task automatic issue(input logic [31:0] ins, input logic inh, output int stalls);
      stalls   = 0;
      instr    = ins;
      inhibit  = inh;
      in_valid = 1'b1;
      while (1) begin
         @(negedge clk);
         if (in_ready) break;
         stalls++;
         if (stalls > 20) begin
            check("accept_timeout", 64'(in_ready), 64'(1));
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      inhibit  = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int st;
      int busy;
      rst       = 1'b1;
      in_valid  = 1'b0;
      instr     = '0;
      inhibit   = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_bundle", 64'(act_vec), 64'(0));
      check("reset_out_valid", 64'(out_valid), 64'(0));
      check("reset_in_ready", 64'(in_ready), 64'(0));
      step();
      rst = 1'b0;

      exp_q.push_back(pack(1, 1, 2'b10, 0, 4'h0, 0, 0, 0, 0, 0, 0, 5'd8, I_ADD8));
      issue(I_ADD8, 1'b0, st);
      check("add_no_stall", 64'(st), 64'(0));

      // load-use through rs
      exp_q.push_back(pack(0, 1, 2'b00, 1, 4'h0, 1, 0, 0, 0, 0, 0, 5'd8, I_LW8));
      issue(I_LW8, 1'b0, st);
      exp_q.push_back(pack(1, 1, 2'b10, 0, 4'h0, 0, 0, 0, 0, 0, 0, 5'd10, I_ADD10));
      issue(I_ADD10, 1'b0, st);
      check("lw_rs_stall", 64'(st), 64'(1));

      exp_q.push_back(pack(0, 1, 2'b00, 1, 4'h0, 0, 1, 0, 0, 0, 0, 5'd8, I_ADDI));
      issue(I_ADDI, 1'b0, st);
      exp_q.push_back(pack(1, 1, 2'b10, 0, 4'h0, 0, 0, 0, 0, 0, 0, 5'd10, I_ADD10));
      issue(I_ADD10, 1'b0, st);
      check("addi_no_stall", 64'(st), 64'(0));

      // load-use through rt of a store
      exp_q.push_back(pack(0, 1, 2'b00, 1, 4'h0, 1, 0, 0, 0, 0, 0, 5'd8, I_LW8));
      issue(I_LW8, 1'b0, st);
      exp_q.push_back(pack(0, 0, 2'b00, 1, 4'hF, 0, 0, 0, 0, 0, 0, 5'd8, I_SW));
      issue(I_SW, 1'b0, st);
      check("lw_rt_stall", 64'(st), 64'(1));

      // a load to $0 never stalls
      exp_q.push_back(pack(0, 1, 2'b00, 1, 4'h0, 1, 0, 0, 0, 0, 0, 5'd0, I_LW0));
      issue(I_LW0, 1'b0, st);
      exp_q.push_back(pack(1, 1, 2'b10, 0, 4'h0, 0, 0, 0, 0, 0, 0, 5'd10, I_ADD00));
      issue(I_ADD00, 1'b0, st);
      check("lw_r0_no_stall", 64'(st), 64'(0));

      exp_q.push_back(pack(0, 0, 2'b01, 0, 4'h0, 0, 0, 1, 0, 0, 0, 5'd9, I_BEQ));
      issue(I_BEQ, 1'b0, st);
      exp_q.push_back(pack(0, 0, 2'b01, 0, 4'h0, 0, 0, 0, 1, 0, 0, 5'd9, I_BNE));
      issue(I_BNE, 1'b0, st);
      exp_q.push_back(pack(0, 1, 2'b01, 1, 4'h0, 0, 1, 0, 0, 0, 0, 5'd8, I_SLTI));
      issue(I_SLTI, 1'b0, st);

      // multiply occupancy
      exp_q.push_back(pack(1, 0, 2'b11, 0, 4'h0, 0, 0, 0, 0, 1, 0, 5'd0, I_MULT));
      issue(I_MULT, 1'b0, st);
      busy = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (in_ready) break;
         busy++;
      end
      check("mult_busy_cycles", 64'(busy), 64'(3));
      step();

      exp_q.push_back(pack(1, 0, 2'b11, 0, 4'h0, 0, 0, 0, 0, 1, 0, 5'd0, I_MULTU));
      issue(I_MULTU, 1'b0, st);
      exp_q.push_back(pack(0, 1, 2'b00, 1, 4'h0, 0, 1, 0, 0, 0, 0, 5'd8, I_ADDI));
      issue(I_ADDI, 1'b0, st);
      check("multu_stall", 64'(st), 64'(3));

      // back-pressure holds a store
      exp_q.push_back(pack(0, 0, 2'b00, 1, 4'hF, 0, 0, 0, 0, 0, 0, 5'd8, I_SW));
      issue(I_SW, 1'b0, st);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_valid", 64'(out_valid), 64'(1));
         check("hold_mem_write", 64'(out_mem_write), 64'(4'hF));
         check("hold_instr", 64'(out_instr), 64'(I_SW));
         check("hold_in_ready", 64'(in_ready), 64'(0));
         step();
      end
      out_ready = 1'b1;
      step();

      // flush while the multiplier still has two cycles to go
      exp_q.push_back(pack(1, 0, 2'b11, 0, 4'h0, 0, 0, 0, 0, 1, 0, 5'd0, I_MULT));
      issue(I_MULT, 1'b0, st);
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      @(negedge clk);
      check("flush_out_valid", 64'(out_valid), 64'(0));
      check("flush_in_ready", 64'(in_ready), 64'(1));
      check("flush_state", 64'(dbg_state), 64'(ST_RUN));
      step();

      // flush discards a bundle held by back-pressure
      issue(I_ADDI, 1'b0, st);
      out_ready = 1'b0;
      flush     = 1'b1;
      step();
      flush     = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("flush_kill_valid", 64'(out_valid), 64'(0));
      step();

      issue(I_ADD8, 1'b1, st);
      @(negedge clk);
      check("inhibit_bubble", 64'(out_valid), 64'(0));
      step();

      exp_q.push_back(pack(0, 0, 2'b00, 0, 4'h0, 0, 0, 0, 0, 0, 1, 5'd0, I_ILL));
      issue(I_ILL, 1'b0, st);

      // reset in the middle of traffic
      issue(I_ADDI, 1'b0, st);
      rst       = 1'b1;
      out_ready = 1'b0;
      step();
      @(negedge clk);
      check("midrst_bundle", 64'(act_vec), 64'(0));
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_in_ready", 64'(in_ready), 64'(0));
      step();
      rst       = 1'b0;
      out_ready = 1'b1;

      repeat (3) step();
      check("queue_drained", 64'(exp_q.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
